dac_spi_tx: RTL and testbench
=============================

Name: dac_spi_tx

Overview:
- Downstream consumer of the 8-bit sine sample stream. Serialises each accepted sample into one 16-bit SPI frame for an external serial DAC.
- SPI mode 0, MSB first: SCLK idles low, MOSI changes on SCLK falling edges, the DAC samples on rising edges.
- Runs in the system clock domain. The upstream sample strobe is a single-cycle pulse already synchronous to clk.
- Provides busy/done status and a sticky overrun flag for samples dropped while a frame is in flight.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range 1..255.
- CMD, 4'h0, 4-bit DAC command/control nibble placed in frame bits [15:12].

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- sample_in  input  8  sample value; sampled only on an accept edge.
- sample_valid  input  1  single-cycle strobe indicating sample_in is valid.
- ovr_clr  input  1  synchronous clear of overrun.
- dac_cs_n  output  1  DAC chip select, active low.
- dac_sclk  output  1  SPI serial clock.
- dac_mosi  output  1  SPI serial data.
- busy  output  1  high from accept until the frame plus guard time completes.
- done  output  1  one-cycle pulse when dac_cs_n returns high.
- overrun  output  1  sticky: a sample_valid arrived while busy.

Behaviour:
- Reset values (rst high, immediate, asynchronous):
  - dac_cs_n=1, dac_sclk=0, dac_mosi=0, busy=0, done=0, overrun=0.
  - FSM returns to IDLE and counters clear.
  - Reset mid-frame aborts the frame; no done pulse is produced.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Frame format: {CMD[3:0], sample_in[7:0], 4'b0000}, shifted MSB (bit 15) first.
- States: IDLE -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - Accept edge T0 occurs when sample_valid=1 in IDLE.
  - At T0: latch the frame, busy<=1, dac_cs_n<=0, dac_mosi<=frame[15], sclk stays low, enter SHIFT.
- SHIFT, per bit:
  - SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - At each high->low transition, MOSI advances to the next bit.
  - After bit 0's high phase: sclk<=0, MOSI holds bit 0, enter HOLD.
  - This edge is T0+32*CLK_DIV.
- HOLD:
  - dac_cs_n stays low for CLK_DIV cycles.
  - At T0+33*CLK_DIV: dac_cs_n<=1, done<=1 for exactly one cycle, dac_mosi<=0, enter GAP.
- GAP:
  - CS-high guard of CLK_DIV cycles.
  - At T0+34*CLK_DIV: busy<=0, enter IDLE.
  - The earliest next accept edge is T0+34*CLK_DIV+1.
- Timing at CLK_DIV=4: dac_cs_n low 132 cycles, busy high 136 cycles, 16 SCLK rising edges.
- Maximum sample rate is one per 34*CLK_DIV+1 clk cycles. The upstream sync period must respect this; otherwise overrun.
- Overrun handling:
  - sample_valid while state≠IDLE drops the sample; the frame in flight is unaffected; overrun<=1.
  - ovr_clr clears overrun. If a set and ovr_clr occur on the same edge, set wins and overrun stays 1.
- sample_in is don't-care except on accept edges.
- A sample_valid held high for multiple cycles is treated as repeated strobes: the first is accepted, the rest set overrun.
- Counters:
  - Half-period counter is 8 bits, counting 0..CLK_DIV-1.
  - Bit counter is 4 bits, counting 15..0.
  - No wrap beyond frame end; the counter terminal value forces the state change.

Test Plan:
- Single frame: CLK_DIV=4, CMD=0, sample_in=8'hB3, pulse at T0 -> SPI monitor captures 16'h0B30 on 16 sclk rises; cs_n low T0..T0+132; done single pulse at T0+132; busy falls at T0+136.
- Sine sweep: feed the 16-entry sequence 80,B3,DE,F9,FE,EE,CA,9A,65,35,11,01,06,21,4C,7F, spaced 140 cycles -> 16 frames captured in order with data bits [11:4] matching; overrun stays 0.
- Overrun: second pulse at T0+50 with sample 8'h11 -> frame 1 completes unchanged, no second frame, overrun=1. ovr_clr pulse -> 0. ovr_clr coincident with a new busy-time strobe -> overrun stays 1.
- Reset mid-frame: assert rst at T0+60 -> cs_n=1, sclk=0, mosi=0, busy=0 immediately, no done. After release, a new sample 8'h65 transmits cleanly as 16'h0650.
- Boundary CLK_DIV=1, CMD=4'hA, sample 8'hFF -> frame 16'hAFF0, sclk toggles every cycle, busy high 34 cycles. A strobe at exactly T0+34 sets overrun; a strobe at T0+35 is accepted.

Source files
------------

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises each accepted 8-bit sample into a 16-bit SPI mode-0
// frame {CMD, sample, 4'b0000} for an external serial DAC, MSB first.
// Provides busy/done status and a sticky overrun flag for dropped samples.
module dac_spi_tx #(
    parameter int         CLK_DIV = 4,
    parameter logic [3:0] CMD     = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    input  logic       ovr_clr,
    output logic       dac_cs_n,
    output logic       dac_sclk,
    output logic       dac_mosi,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state, state_nxt;
    logic [7:0]  div_cnt, div_nxt;
    logic [3:0]  bit_cnt, bit_nxt;
    logic [15:0] shreg, shreg_nxt;
    logic        cs_n_nxt, sclk_nxt, mosi_nxt, busy_nxt, done_nxt, overrun_nxt;
    logic        div_term;

    assign div_term = (div_cnt == DIV_LAST);

    // State, counters and all outputs are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            dac_cs_n <= 1'b1;
            dac_sclk <= 1'b0;
            dac_mosi <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= shreg_nxt;
            dac_cs_n <= cs_n_nxt;
            dac_sclk <= sclk_nxt;
            dac_mosi <= mosi_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            overrun  <= overrun_nxt;
        end
    end

    // Next-state: each phase ends on the half-period counter terminal value
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (sample_valid) state_nxt = SHIFT;
            SHIFT: if (div_term && dac_sclk && (bit_cnt == 4'd0)) state_nxt = HOLD;
            HOLD:  if (div_term) state_nxt = GAP;
            GAP:   if (div_term) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        cs_n_nxt  = dac_cs_n;
        sclk_nxt  = dac_sclk;
        mosi_nxt  = dac_mosi;
        busy_nxt  = busy;
        done_nxt  = 1'b0;

        // A strobe outside IDLE is dropped; setting beats a same-cycle clear
        overrun_nxt = overrun;
        if (ovr_clr) overrun_nxt = 1'b0;
        if (sample_valid && (state != IDLE)) overrun_nxt = 1'b1;

        if (state != IDLE) div_nxt = div_term ? 8'd0 : div_cnt + 8'd1;

        case (state)
            IDLE: begin
                div_nxt = '0;
                if (sample_valid) begin
                    shreg_nxt = {CMD, sample_in, 4'b0000};
                    mosi_nxt  = CMD[3];
                    cs_n_nxt  = 1'b0;
                    sclk_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                    bit_nxt   = 4'd15;
                end
            end
            SHIFT: begin
                if (div_term) begin
                    if (!dac_sclk) begin
                        sclk_nxt = 1'b1;
                    end else begin
                        // Falling edge: advance MOSI unless the last bit just finished
                        sclk_nxt = 1'b0;
                        if (bit_cnt != 4'd0) begin
                            bit_nxt   = bit_cnt - 4'd1;
                            shreg_nxt = {shreg[14:0], 1'b0};
                            mosi_nxt  = shreg[14];
                        end
                    end
                end
            end
            HOLD: begin
                if (div_term) begin
                    cs_n_nxt = 1'b1;
                    done_nxt = 1'b1;
                    mosi_nxt = 1'b0;
                end
            end
            GAP: begin
                if (div_term) busy_nxt = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Testbench for dac_spi_tx: two instances (CLK_DIV=4/CMD=0 and CLK_DIV=1/CMD=A),
// SPI monitors that reassemble frames and compare them against a queue of
// expected frames pushed when each sample is driven.
module tb_dac_spi_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0] si4 = '0, si1 = '0;
    logic       sv4 = 1'b0, sv1 = 1'b0, clr4 = 1'b0, clr1 = 1'b0;
    logic       cs4, sclk4, mosi4, busy4, done4, ovr4;
    logic       cs1, sclk1, mosi1, busy1, done1, ovr1;

    int checks = 0;
    int errors = 0;

    logic [15:0] q4[$];
    logic [15:0] q1[$];
    int frames4 = 0, frames1 = 0, dones4 = 0, dones1 = 0;

    always #5 clk = ~clk;

    dac_spi_tx #(.CLK_DIV(4), .CMD(4'h0)) u4 (
        .clk(clk), .rst(rst), .sample_in(si4), .sample_valid(sv4), .ovr_clr(clr4),
        .dac_cs_n(cs4), .dac_sclk(sclk4), .dac_mosi(mosi4),
        .busy(busy4), .done(done4), .overrun(ovr4)
    );

    dac_spi_tx #(.CLK_DIV(1), .CMD(4'hA)) u1 (
        .clk(clk), .rst(rst), .sample_in(si1), .sample_valid(sv1), .ovr_clr(clr1),
        .dac_cs_n(cs1), .dac_sclk(sclk1), .dac_mosi(mosi1),
        .busy(busy1), .done(done1), .overrun(ovr1)
    );

    // SPI monitor for u4: capture on sclk rise, score at cs_n rise
    logic [15:0] sh4 = '0;
    int   cnt4 = 0;
    logic pcs4 = 1'b1, psclk4 = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            cnt4 = 0; pcs4 = 1'b1; psclk4 = 1'b0;
        end else begin
            if (done4) dones4++;
            if (!cs4 && sclk4 && !psclk4) begin
                sh4 = {sh4[14:0], mosi4};
                cnt4++;
            end
            if (cs4 && !pcs4) begin
                checks++;
                if (q4.size() == 0) begin
                    errors++;
                    $display("FAIL frame4: got %h with %0d bits, expected no frame", sh4, cnt4);
                end else begin
                    if (sh4 !== q4[0] || cnt4 != 16) begin
                        errors++;
                        $display("FAIL frame4: got %h with %0d bits, expected %h with 16 bits", sh4, cnt4, q4[0]);
                    end
                    void'(q4.pop_front());
                end
                frames4++;
                cnt4 = 0;
            end
            pcs4 = cs4; psclk4 = sclk4;
        end
    end

    // SPI monitor for u1
    logic [15:0] sh1 = '0;
    int   cnt1 = 0;
    logic pcs1 = 1'b1, psclk1 = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            cnt1 = 0; pcs1 = 1'b1; psclk1 = 1'b0;
        end else begin
            if (done1) dones1++;
            if (!cs1 && sclk1 && !psclk1) begin
                sh1 = {sh1[14:0], mosi1};
                cnt1++;
            end
            if (cs1 && !pcs1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL frame1: got %h with %0d bits, expected no frame", sh1, cnt1);
                end else begin
                    if (sh1 !== q1[0] || cnt1 != 16) begin
                        errors++;
                        $display("FAIL frame1: got %h with %0d bits, expected %h with 16 bits", sh1, cnt1, q1[0]);
                    end
                    void'(q1.pop_front());
                end
                frames1++;
                cnt1 = 0;
            end
            pcs1 = cs1; psclk1 = sclk1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Strobe one sample; returns #1 after the accept edge T0
    task automatic pulse4(input logic [7:0] d);
        si4 = d; sv4 = 1'b1;
        @(posedge clk); #1;
        sv4 = 1'b0;
    endtask

    task automatic pulse1(input logic [7:0] d);
        si1 = d; sv1 = 1'b1;
        @(posedge clk); #1;
        sv1 = 1'b0;
    endtask

    task automatic test_reset;
        cyc(3);
        checks++;
        if ({cs4, sclk4, mosi4, busy4, done4, ovr4} !== 6'b100000) begin
            errors++;
            $display("FAIL reset4: got %b expected 100000", {cs4, sclk4, mosi4, busy4, done4, ovr4});
        end
        checks++;
        if ({cs1, sclk1, mosi1, busy1, done1, ovr1} !== 6'b100000) begin
            errors++;
            $display("FAIL reset1: got %b expected 100000", {cs1, sclk1, mosi1, busy1, done1, ovr1});
        end
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic test_single;
        int f0 = frames4;
        int d0 = dones4;
        q4.push_back(16'h0B30);
        pulse4(8'hB3);
        checks++;
        if ({cs4, busy4, sclk4, mosi4} !== 4'b0100) begin
            errors++;
            $display("FAIL single_t0: cs/busy/sclk/mosi got %b expected 0100", {cs4, busy4, sclk4, mosi4});
        end
        cyc(131);
        checks++;
        if ({cs4, done4} !== 2'b00) begin
            errors++;
            $display("FAIL single_t131: cs/done got %b expected 00", {cs4, done4});
        end
        cyc(1);
        checks++;
        if ({cs4, done4, busy4} !== 3'b111) begin
            errors++;
            $display("FAIL single_t132: cs/done/busy got %b expected 111", {cs4, done4, busy4});
        end
        cyc(1);
        checks++;
        if ({done4, busy4} !== 2'b01) begin
            errors++;
            $display("FAIL single_t133: done/busy got %b expected 01", {done4, busy4});
        end
        cyc(2);
        checks++;
        if (busy4 !== 1'b1) begin
            errors++;
            $display("FAIL single_t135: busy got %b expected 1", busy4);
        end
        cyc(1);
        checks++;
        if (busy4 !== 1'b0) begin
            errors++;
            $display("FAIL single_t136: busy got %b expected 0", busy4);
        end
        cyc(4);
        checks++;
        if (frames4 != f0 + 1 || dones4 != d0 + 1) begin
            errors++;
            $display("FAIL single_count: frames %0d dones %0d expected 1 and 1", frames4 - f0, dones4 - d0);
        end
    endtask

    task automatic test_sine_sweep;
        logic [7:0] tbl [16] = '{8'h80, 8'hB3, 8'hDE, 8'hF9, 8'hFE, 8'hEE, 8'hCA, 8'h9A,
                                 8'h65, 8'h35, 8'h11, 8'h01, 8'h06, 8'h21, 8'h4C, 8'h7F};
        int f0 = frames4;
        for (int i = 0; i < 16; i++) begin
            q4.push_back({4'h0, tbl[i], 4'h0});
            pulse4(tbl[i]);
            cyc(139);
        end
        checks++;
        if (frames4 != f0 + 16 || q4.size() != 0 || ovr4 !== 1'b0) begin
            errors++;
            $display("FAIL sweep: frames %0d left %0d overrun %b expected 16 0 0", frames4 - f0, q4.size(), ovr4);
        end
    endtask

    task automatic test_overrun;
        int f0 = frames4;
        q4.push_back(16'h03C0);
        pulse4(8'h3C);
        cyc(49);
        pulse4(8'h11);
        checks++;
        if ({ovr4, busy4} !== 2'b11) begin
            errors++;
            $display("FAIL ovr_set: overrun/busy got %b expected 11", {ovr4, busy4});
        end
        cyc(90);
        checks++;
        if (frames4 != f0 + 1 || q4.size() != 0) begin
            errors++;
            $display("FAIL ovr_frames: frames %0d left %0d expected 1 0", frames4 - f0, q4.size());
        end
        clr4 = 1'b1;
        cyc(1);
        clr4 = 1'b0;
        checks++;
        if (ovr4 !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clr: overrun got %b expected 0", ovr4);
        end
        q4.push_back(16'h0C60);
        pulse4(8'hC6);
        cyc(20);
        si4 = 8'h99; sv4 = 1'b1; clr4 = 1'b1;
        cyc(1);
        sv4 = 1'b0; clr4 = 1'b0;
        checks++;
        if (ovr4 !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set_wins: overrun got %b expected 1", ovr4);
        end
        cyc(120);
        clr4 = 1'b1;
        cyc(1);
        clr4 = 1'b0;
        checks++;
        if (frames4 != f0 + 2 || ovr4 !== 1'b0) begin
            errors++;
            $display("FAIL ovr_tail: frames %0d overrun %b expected 2 0", frames4 - f0, ovr4);
        end
    endtask

    task automatic test_reset_mid_frame;
        int d0 = dones4;
        int f0;
        pulse4(8'h77);
        cyc(59);
        rst = 1'b1;
        #1;
        checks++;
        if ({cs4, sclk4, mosi4, busy4, done4} !== 5'b10000) begin
            errors++;
            $display("FAIL rst_mid: cs/sclk/mosi/busy/done got %b expected 10000", {cs4, sclk4, mosi4, busy4, done4});
        end
        cyc(2);
        rst = 1'b0;
        cyc(2);
        f0 = frames4;
        q4.push_back(16'h0650);
        pulse4(8'h65);
        cyc(140);
        checks++;
        if (frames4 != f0 + 1 || dones4 != d0 + 1 || q4.size() != 0) begin
            errors++;
            $display("FAIL rst_recover: frames %0d dones %0d left %0d expected 1 1 0",
                     frames4 - f0, dones4 - d0, q4.size());
        end
    endtask

    task automatic test_clkdiv1;
        int f0 = frames1;
        int bad = 0;
        q1.push_back(16'hAFF0);
        pulse1(8'hFF);
        for (int k = 1; k <= 32; k++) begin
            cyc(1);
            if (sclk1 !== ((k % 2) == 1)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL div1_sclk: %0d wrong sclk cycles, expected 0", bad);
        end
        cyc(1);
        checks++;
        if ({busy1, cs1, done1} !== 3'b111) begin
            errors++;
            $display("FAIL div1_t33: busy/cs/done got %b expected 111", {busy1, cs1, done1});
        end
        si1 = 8'h22; sv1 = 1'b1;
        cyc(1);
        checks++;
        if ({busy1, ovr1} !== 2'b01) begin
            errors++;
            $display("FAIL div1_t34: busy/overrun got %b expected 01", {busy1, ovr1});
        end
        si1 = 8'h5A;
        q1.push_back(16'hA5A0);
        cyc(1);
        sv1 = 1'b0;
        checks++;
        if ({busy1, cs1} !== 2'b10) begin
            errors++;
            $display("FAIL div1_t35: busy/cs got %b expected 10", {busy1, cs1});
        end
        cyc(40);
        clr1 = 1'b1;
        cyc(1);
        clr1 = 1'b0;
        checks++;
        if (frames1 != f0 + 2 || q1.size() != 0 || ovr1 !== 1'b0) begin
            errors++;
            $display("FAIL div1_frames: frames %0d left %0d overrun %b expected 2 0 0",
                     frames1 - f0, q1.size(), ovr1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sine_sweep();
        test_overrun();
        test_reset_mid_frame();
        test_clkdiv1();
        checks++;
        if (q4.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL queues: left %0d and %0d expected 0 and 0", q4.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
